// File: rtl/drain_ctrl_pkg.sv
// Shared constants, state encoding and sizing helper for the result-drain sequencer.
package drain_ctrl_pkg;

    localparam int unsigned SYS_ARRAY_SIZE = 4;

    typedef logic [1:0] drain_state_t;

    localparam drain_state_t StIdle = 2'd0;
    localparam drain_state_t StRun  = 2'd1;
    localparam drain_state_t StDone = 2'd2;

    // Wide enough for the beat counter to reach the last row's beat without wrapping.
    function automatic int unsigned drain_cnt_w(input int unsigned rows,
                                                input int unsigned drain_w);
        return $clog2(2 * rows + 2 * drain_w);
    endfunction

endpackage

// File: rtl/drain_ctrl.sv
// Result-drain sequencer: steps the drain chain, drives the pair select and issues one
// valid/ready row write per completed matrix row, freezing the drain under back-pressure.
module drain_ctrl
    import drain_ctrl_pkg::*;
#(
    parameter int unsigned ROWS    = SYS_ARRAY_SIZE,
    parameter int unsigned DRAIN_W = (SYS_ARRAY_SIZE + 1) / 2,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              flush_i,
    output logic              drain_en_o,
    output logic              ctrl_o,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned FIRST = 2 * DRAIN_W - 1;
    localparam int unsigned CW    = drain_cnt_w(ROWS, DRAIN_W);

    localparam logic [CW-1:0] FirstC   = CW'(FIRST);
    localparam logic [CW-1:0] RowsC    = CW'(ROWS);
    localparam logic [CW-1:0] LastRowC = CW'(ROWS - 1);

    drain_state_t      state_q, state_d;
    logic [CW-1:0]     beat_q, beat_d;
    logic [CW-1:0]     row_q, row_d;
    logic              phase_q, phase_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic run, valid, adv, hs;

    always_comb begin
        run   = (state_q == StRun);
        // FIRST is odd, so rows sit on beats of the same parity as FIRST.
        valid = run && (beat_q >= FirstC) && (beat_q[0] == FirstC[0]) && (row_q < RowsC);
        adv   = run && (!valid || wr_ready_i);
        hs    = valid && wr_ready_i;

        drain_en_o = adv;
        ctrl_o     = run & phase_q;
        wr_valid_o = valid;
        wr_addr_o  = run ? base_q + ADDR_W'(row_q) : '0;
        busy_o     = run;
        done_o     = (state_q == StDone);
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        row_d   = row_q;
        phase_d = phase_q;
        base_d  = base_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    base_d  = base_addr_i;
                    beat_d  = '0;
                    row_d   = '0;
                    phase_d = 1'b0;
                end
            end
            StRun: begin
                if (adv) begin
                    beat_d  = beat_q + 1'b1;
                    phase_d = ~phase_q;
                end
                if (hs) begin
                    row_d = row_q + 1'b1;
                    if (row_q == LastRowC) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                beat_d  = '0;
                row_d   = '0;
                phase_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        if (flush_i) begin
            state_d = StIdle;
            beat_d  = '0;
            row_d   = '0;
            phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            beat_q  <= '0;
            row_q   <= '0;
            phase_q <= 1'b0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            row_q   <= row_d;
            phase_q <= phase_d;
            base_q  <= base_d;
        end
    end

    a_hold_while_stalled: assert property (@(posedge clk_i) disable iff (rst_i)
        (wr_valid_o && !wr_ready_i && !flush_i) |=> (wr_valid_o && $stable(wr_addr_o)));

    a_en_only_in_run: assert property (@(posedge clk_i) disable iff (rst_i)
        drain_en_o |-> (state_q == StRun));

    a_done_single: assert property (@(posedge clk_i) disable iff (rst_i)
        done_o |=> !done_o);

endmodule

// File: tb/tb_drain_ctrl.sv
// Bench for drain_ctrl: a 4-row and a 3-row instance share stimulus and are compared every
// cycle against a beat/row arithmetic model of the drain pass.
module tb_drain_ctrl;

    localparam int FIRST = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       flush;
    logic       ready;
    logic [7:0] base;

    logic       en   [2];
    logic       ctrl [2];
    logic       val  [2];
    logic       busy [2];
    logic       done [2];
    logic [7:0] addr [2];

    always #5 clk = ~clk;

    drain_ctrl #(.ROWS(4), .DRAIN_W(2), .ADDR_W(8)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .flush_i(flush),
        .drain_en_o(en[0]), .ctrl_o(ctrl[0]), .wr_valid_o(val[0]), .wr_ready_i(ready),
        .wr_addr_o(addr[0]), .busy_o(busy[0]), .done_o(done[0])
    );

    drain_ctrl #(.ROWS(3), .DRAIN_W(2), .ADDR_W(8)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .flush_i(flush),
        .drain_en_o(en[1]), .ctrl_o(ctrl[1]), .wr_valid_o(val[1]), .wr_ready_i(ready),
        .wr_addr_o(addr[1]), .busy_o(busy[1]), .done_o(done[1])
    );

    // Model: state 0=idle 1=run 2=done; beat counts drain advances, row counts accepted rows.
    int rows_of [2] = '{4, 3};
    int m_st    [2];
    int m_beat  [2];
    int m_row   [2];
    int m_base  [2];

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;
    logic [7:0] q_addr[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic m_valid(input int i);
        return (m_st[i] == 1) && (m_beat[i] >= FIRST) && ((m_beat[i] - FIRST) % 2 == 0)
            && (m_row[i] < rows_of[i]);
    endfunction

    function automatic logic [12:0] expect_out(input int i);
        logic       run, v, a_en, c;
        logic [7:0] a;
        run  = (m_st[i] == 1);
        v    = m_valid(i);
        a_en = run && (!v || ready);
        c    = run && (m_beat[i] % 2 == 1);
        a    = run ? 8'((m_base[i] + m_row[i]) % 256) : 8'h00;
        return {a_en, c, v, run, (m_st[i] == 2), a};
    endfunction

    function automatic logic [12:0] observe(input int i);
        return {en[i], ctrl[i], val[i], busy[i], done[i], addr[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_beat[i] = 0; m_row[i] = 0; m_base[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            logic v, a_en;
            v    = m_valid(i);
            a_en = (m_st[i] == 1) && (!v || ready);
            if (flush) begin
                m_st[i] = 0; m_beat[i] = 0; m_row[i] = 0;
            end else if (m_st[i] == 0) begin
                if (start) begin
                    m_st[i] = 1; m_base[i] = base; m_beat[i] = 0; m_row[i] = 0;
                end
            end else if (m_st[i] == 1) begin
                if (v && ready) m_row[i]++;
                if (a_en) m_beat[i]++;
                if (m_row[i] == rows_of[i]) m_st[i] = 2;
            end else begin
                m_st[i] = 0;
            end
        end
    endtask

    // Inputs are set at edge+1; outputs checked at edge+2.
    task automatic cycle(input string tag);
        #1;
        for (int i = 0; i < 2; i++)
            check($sformatf("%s inst%0d c%0d", tag, i, cyc), 32'(observe(i)), 32'(expect_out(i)));
        if (val[0] && ready) q_addr.push_back(addr[0]);
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic run_pass(input logic [7:0] b, input int stall_lo, input int stall_hi,
                            input int ncyc, output int done_a, output int done_b,
                            output int ndone_a);
        base = b; start = 1'b1; ready = 1'b1; flush = 1'b0;
        cyc = 0; done_a = -1; done_b = -1; ndone_a = 0;
        q_addr.delete();
        cycle("start");
        start = 1'b0;
        repeat (ncyc) begin
            ready = !(cyc >= stall_lo && cyc <= stall_hi);
            cycle("pass");
            if (done[0]) begin
                ndone_a++;
                if (done_a < 0) done_a = cyc;
            end
            if (done[1] && done_b < 0) done_b = cyc;
        end
    endtask

    initial begin
        int da, db, nd;
        logic [7:0] wrap_exp [4];

        rst = 1'b1; start = 1'b0; flush = 1'b0; ready = 1'b0; base = 8'h00;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) check("reset", 32'(observe(i)), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Pass with ready tied high.
        run_pass(8'h10, -1, -1, 13, da, db, nd);
        check("p1 done cycle", 32'(da), 32'd11);
        check("p1 done3 cycle", 32'(db), 32'd9);
        check("p1 rows", 32'(q_addr.size()), 32'd4);

        // Stall on row 1 for three cycles.
        run_pass(8'h10, 6, 8, 16, da, db, nd);
        check("p2 done cycle", 32'(da), 32'd14);
        check("p2 done3 cycle", 32'(db), 32'd12);

        // Address wrap.
        run_pass(8'hFE, -1, -1, 13, da, db, nd);
        wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        check("p3 ndone", 32'(nd), 32'd1);
        check("p3 rows", 32'(q_addr.size()), 32'd4);
        for (int k = 0; k < 4 && k < q_addr.size(); k++)
            check($sformatf("p3 addr%0d", k), 32'(q_addr[k]), 32'(wrap_exp[k]));

        // Flush mid-pass then restart.
        base = 8'h20; start = 1'b1; ready = 1'b1; cyc = 0; da = -1; nd = 0;
        cycle("p4 start");
        repeat (23) begin
            flush = (cyc == 7);
            start = (cyc == 9);
            cycle("p4");
            if (cyc == 8) check("p4 busy after flush", 32'(busy[0]), 32'd0);
            if (done[0]) begin
                nd++;
                if (da < 0) da = cyc;
            end
        end
        flush = 1'b0; start = 1'b0;
        check("p4 ndone", 32'(nd), 32'd1);
        check("p4 done cycle", 32'(da), 32'd20);

        // Async reset mid-run, with a start during run ignored.
        base = 8'h40; start = 1'b1; cyc = 0;
        cycle("p5 start");
        repeat (5) begin
            start = (cyc == 3);
            cycle("p5");
        end
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) check("p5 async reset", 32'(observe(i)), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // Start asserted during DONE must be ignored.
        base = 8'h50; start = 1'b1; cyc = 0;
        cycle("p6 start");
        repeat (13) begin
            start = (cyc == 11);
            cycle("p6");
            if (cyc == 12) check("p6 start in done ignored", 32'(busy[0]), 32'd0);
        end
        start = 1'b0;

        // Randomized traffic.
        repeat (400) begin
            start = ($urandom_range(7) == 0);
            flush = ($urandom_range(40) == 0);
            ready = ($urandom_range(3) != 0);
            base  = 8'($urandom);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
